axi_rd_slave: RTL

AXI_RD_SLAVE -- requirements
Module: axi_rd_slave

---
 rtl/axi_pkg.sv | 21 ++
 rtl/axi_rd_addr_gen.sv | 35 +++
 rtl/axi_rd_slave.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI read-slave definitions: burst types, response codes, FSM states.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_e;

    // A wrapping burst is only legal for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Next-beat byte address for FIXED / INCR / WRAP bursts (purely combinational).
module axi_rd_addr_gen #(
    parameter int AW = 32
) (
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    len_i,
    input  logic [2:0]    size_i,
    input  logic [1:0]    burst_i,
    output logic [AW-1:0] next_addr_o
);
    import axi_pkg::*;

    logic [AW-1:0] beat_bytes;
    logic [AW-1:0] size_mask;
    logic [AW-1:0] aligned_addr;
    logic [AW-1:0] incr_addr;
    logic [AW-1:0] wrap_bytes;
    logic [AW-1:0] wrap_mask;

    // Align to the beat size, step one beat, and fold into the wrap window for WRAP.
    always_comb begin
        beat_bytes   = AW'(1) << size_i;
        size_mask    = beat_bytes - AW'(1);
        aligned_addr = addr_i & ~size_mask;
        incr_addr    = aligned_addr + beat_bytes;
        wrap_bytes   = (AW'(len_i) + AW'(1)) << size_i;
        wrap_mask    = wrap_bytes - AW'(1);
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr_o = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_rd_slave.sv
// AXI read slave backed by a preloadable block RAM; one outstanding burst at a time.
module axi_rd_slave #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               ARID,
    input  logic [AW-1:0]            ARADDR,
    input  logic [3:0]               ARLEN,
    input  logic [2:0]               ARSIZE,
    input  logic [1:0]               ARBURST,
    input  logic [1:0]               ARLOCK,
    input  logic [3:0]               ARCACHE,
    input  logic [2:0]               ARPROT,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [3:0]               RID,
    output logic [DW-1:0]            RDATA,
    output logic [1:0]               RRESP,
    output logic                     RLAST,
    output logic                     RVALID,
    input  logic                     RREADY,
    input  logic                     mem_we,
    input  logic [$clog2(DEPTH)-1:0] mem_waddr,
    input  logic [DW-1:0]            mem_wdata
);
    import axi_pkg::*;

    localparam int         IW         = $clog2(DEPTH);
    localparam int         LOG2_BYTES = $clog2(DW / 8);
    localparam logic [2:0] MAX_SIZE   = 3'(LOG2_BYTES);

    rd_state_e     state_q, state_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic          rlast_q, rlast_d;
    logic [1:0]    rresp_q, rresp_d;
    logic          rdata_ok_q, rdata_ok_d;
    logic [3:0]    id_q, id_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    len_q, len_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    burst_q, burst_d;
    logic          burst_err_q, burst_err_d;
    logic [3:0]    cnt_q, cnt_d;

    logic          load;
    logic [AW-1:0] load_addr;
    logic [AW-1:0] load_idx_full;
    logic [IW-1:0] load_idx;
    logic          load_err;
    logic          ar_err;
    logic [AW-1:0] next_addr;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] mem_rd_q;

    // Lock, cache and protection attributes have no effect on this memory.
    logic unused_sideband;
    assign unused_sideband = ^{ARLOCK, ARCACHE, ARPROT};

    axi_rd_addr_gen #(.AW(AW)) u_addr_gen (
        .addr_i      (addr_q),
        .len_i       (len_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    // Burst-wide error: reserved burst type, oversize beat, or illegal wrap length.
    always_comb begin
        ar_err = (ARBURST == 2'b11) || (ARSIZE > MAX_SIZE) ||
                 ((ARBURST == BURST_WRAP) && !wrap_len_ok(ARLEN));
    end

    // Next-state, beat sequencing and response selection for the beat being loaded.
    always_comb begin
        state_d     = state_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        rresp_d     = rresp_q;
        rdata_ok_d  = rdata_ok_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        burst_err_d = burst_err_q;
        cnt_d       = cnt_q;
        load        = 1'b0;
        load_addr   = addr_q;
        load_err    = burst_err_q;

        case (state_q)
            ST_IDLE: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    state_d     = ST_BURST;
                    arready_d   = 1'b0;
                    rvalid_d    = 1'b1;
                    rlast_d     = (ARLEN == 4'd0);
                    id_d        = ARID;
                    addr_d      = ARADDR;
                    len_d       = ARLEN;
                    size_d      = ARSIZE;
                    burst_d     = ARBURST;
                    burst_err_d = ar_err;
                    cnt_d       = 4'd0;
                    load        = 1'b1;
                    load_addr   = ARADDR;
                    load_err    = ar_err;
                end
            end
            ST_BURST: begin
                if (RREADY) begin
                    if (rlast_q) begin
                        state_d   = ST_IDLE;
                        arready_d = 1'b1;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                    end else begin
                        load      = 1'b1;
                        load_addr = next_addr;
                        addr_d    = next_addr;
                        cnt_d     = cnt_q + 4'd1;
                        rlast_d   = ((cnt_q + 4'd1) == len_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        load_idx_full = load_addr >> LOG2_BYTES;
        load_idx      = load_idx_full[IW-1:0];
        if (load) begin
            if (load_err || (load_idx_full >= AW'(DEPTH))) begin
                rresp_d    = RESP_SLVERR;
                rdata_ok_d = 1'b0;
            end else begin
                rresp_d    = RESP_OKAY;
                rdata_ok_d = 1'b1;
            end
        end
    end

    // Control and response registers; reset drops any burst in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rresp_q     <= RESP_OKAY;
            rdata_ok_q  <= 1'b0;
            id_q        <= 4'd0;
            addr_q      <= '0;
            len_q       <= 4'd0;
            size_q      <= 3'd0;
            burst_q     <= BURST_FIXED;
            burst_err_q <= 1'b0;
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rresp_q     <= rresp_d;
            rdata_ok_q  <= rdata_ok_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            burst_err_q <= burst_err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Block RAM: preload write plus registered beat read (a same-word collision returns old data).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (load) begin
            mem_rd_q <= mem[load_idx];
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RRESP   = rresp_q;
    assign RID     = id_q;
    assign RDATA   = rdata_ok_q ? mem_rd_q : '0;

endmodule
